bchecc_fix: RTL and testbench

- Correction stage directly downstream of the BCH ECC core.
- Accepts the stream of error bit-addresses the decoder produces after Chien search and buffers them in a small FIFO.
- Repairs the sector held in the page SRAM by read-modify-write: read byte, XOR with a single-bit mask, write back.
- Reports completion, correction count and failure/overflow status to the NAND controller.

---
 rtl/bchecc_fix_if.sv | 25 ++
 rtl/bchecc_fix.sv | 185 ++++++++++++++++++
 tb/tb_bchecc_fix.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bchecc_fix_if.sv
// Decoder-side error stream and page-SRAM port of the BCH correction stage.
interface bchecc_fix_if #(
    parameter int AW = 10
);
    logic          err_vld_i;
    logic [12:0]   err_addr_i;
    logic          err_last_i;
    logic [7:0]    mem_rdata_i;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_wdata_o;

    // Correction stage side.
    modport slave (
        input  err_vld_i, err_addr_i, err_last_i, mem_rdata_i,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    // Decoder / SRAM side.
    modport master (
        output err_vld_i, err_addr_i, err_last_i, mem_rdata_i,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/bchecc_fix.sv
// BCH correction stage: buffers error bit-addresses from the Chien search
// and repairs the sector in page SRAM by read / XOR single bit / write back.
module bchecc_fix #(
    parameter int DATA_BYTES = 512,
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               fail_i,
    bchecc_fix_if.slave        bus,
    output logic               fix_busy_o,
    output logic               fix_done_o,
    output logic               fix_fail_o,
    output logic               fix_ovf_o,
    output logic [4:0]         fix_cnt_o,
    output logic [3:0]         skip_cnt_o
);
    localparam int            PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [10:0]   DB_LIMIT = 11'(DATA_BYTES);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_MOD, S_WR, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [12:0]   r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0]   r_count;
    logic          r_busy, r_fail, r_ovf, r_last_seen;
    logic [4:0]    r_fix_cnt;
    logic [3:0]    r_skip_cnt;
    logic [AW-1:0] r_addr;
    logic [2:0]    r_bit;
    logic [7:0]    r_data, r_mask;

    logic [12:0]   w_head;
    logic [9:0]    w_head_byte;
    logic          w_in_range, w_fail, w_full, w_pop, w_push_req, w_push, w_drop;

    assign w_head      = r_fifo[r_rptr];
    assign w_head_byte = w_head[12:3];
    assign w_in_range  = {1'b0, w_head_byte} < DB_LIMIT;
    // start_i takes priority over fail_i: a restart never reports failure.
    assign w_fail      = fail_i & r_busy & ~start_i;
    assign w_full      = (r_count == CNT_FULL);
    assign w_pop       = (r_state == S_RD) & ~w_fail & ~start_i;
    assign w_push_req  = bus.err_vld_i & r_busy & ~r_fail & ~w_fail & ~start_i;
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_drop      = w_push_req & w_full & ~w_pop;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode; abort paths override the normal walk.
    always_comb begin
        // NOTE: default assigned first so every path drives w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0)    w_next = S_RD;
                else if (r_last_seen) w_next = S_DONE;
            end
            S_RD: begin
                if (w_in_range)             w_next = S_MOD;
                else if (r_count > CNT_ONE) w_next = S_RD;
                else                        w_next = S_IDLE;
            end
            S_MOD:   w_next = S_WR;
            S_WR:    w_next = (r_count != '0) ? S_RD : S_IDLE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_fail)  w_next = S_DONE;
        if (start_i) w_next = S_IDLE;
    end

    // SRAM port decoded from the current state.
    always_comb begin
        bus.mem_en_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        case (r_state)
            S_RD: begin
                if (w_in_range) begin
                    bus.mem_en_o   = 1'b1;
                    bus.mem_addr_o = AW'(w_head_byte);
                end
            end
            S_WR: begin
                bus.mem_en_o    = 1'b1;
                bus.mem_we_o    = 1'b1;
                bus.mem_addr_o  = r_addr;
                bus.mem_wdata_o = r_data ^ r_mask;
            end
            default: ;
        endcase
    end

    // FIFO pointers and occupancy; start and failure flush the queue.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst || start_i || w_fail) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage array is not reset; r_count alone decides which entries are valid.
        if (w_push) r_fifo[r_wptr] <= bus.err_addr_i;
    end

    // Sector status: busy, sticky flags, saturating counters, last_seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_fail      <= 1'b0;
            r_ovf       <= 1'b0;
            r_last_seen <= 1'b0;
            r_fix_cnt   <= '0;
            r_skip_cnt  <= '0;
        end else if (start_i) begin
            r_busy      <= 1'b1;
            r_fail      <= 1'b0;
            r_ovf       <= 1'b0;
            r_last_seen <= 1'b0;
            r_fix_cnt   <= '0;
            r_skip_cnt  <= '0;
        end else begin
            if (w_next == S_DONE) r_busy <= 1'b0;
            if (w_fail)           r_fail <= 1'b1;
            if (w_drop)           r_ovf  <= 1'b1;
            if (r_state == S_WR && r_fix_cnt != 5'd31)
                r_fix_cnt <= r_fix_cnt + 5'd1;
            if (r_state == S_RD && !w_in_range && !w_fail && r_skip_cnt != 4'd15)
                r_skip_cnt <= r_skip_cnt + 4'd1;
            if (r_state == S_DONE)
                r_last_seen <= 1'b0;
            else if (bus.err_last_i && r_busy)
                r_last_seen <= 1'b1;
        end
    end

    // Read-modify-write datapath: latch target in RD, data and mask in MOD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_bit  <= '0;
            r_data <= '0;
            r_mask <= '0;
        end else begin
            if (r_state == S_RD) begin
                r_addr <= AW'(w_head_byte);
                r_bit  <= w_head[2:0];
            end
            if (r_state == S_MOD) begin
                r_data <= bus.mem_rdata_i;
                r_mask <= 8'h01 << r_bit;
            end
        end
    end

    assign fix_busy_o = r_busy;
    assign fix_done_o = (r_state == S_DONE);
    assign fix_fail_o = r_fail;
    assign fix_ovf_o  = r_ovf;
    assign fix_cnt_o  = r_fix_cnt;
    assign skip_cnt_o = r_skip_cnt;
endmodule

// File: tb/tb_bchecc_fix.sv
// Self-checking bench for bchecc_fix: SRAM model, write monitor and a
// scoreboard of expected byte repairs pushed as errors are issued.
module tb_bchecc_fix;
    localparam int AW = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       fail_i;
    logic       fix_busy_o, fix_done_o, fix_fail_o, fix_ovf_o;
    logic [4:0] fix_cnt_o;
    logic [3:0] skip_cnt_o;

    bchecc_fix_if #(.AW(AW)) bus ();

    bchecc_fix #(.DATA_BYTES(512), .FIFO_DEPTH(16), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .fail_i     (fail_i),
        .bus        (bus),
        .fix_busy_o (fix_busy_o),
        .fix_done_o (fix_done_o),
        .fix_fail_o (fix_fail_o),
        .fix_ovf_o  (fix_ovf_o),
        .fix_cnt_o  (fix_cnt_o),
        .skip_cnt_o (skip_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] byte_idx;
        logic [7:0] mask;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        int            cyc;
    } wr_t;

    exp_t       exp_q[$];
    wr_t        wr_log[$];
    int         done_log[$];
    int         cyc = 0;
    int         en_cnt = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [1 << AW];
    logic [7:0] ref_mem [1 << AW];

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37) ^ 90);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous page SRAM: read data valid the cycle after the request.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= pat(i);
            bus.mem_rdata_i <= 8'h00;
        end else if (bus.mem_en_o === 1'b1) begin
            if (bus.mem_we_o === 1'b1) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
            else                       bus.mem_rdata_i <= mem[bus.mem_addr_o];
        end
    end

    // Monitor sampling DUT outputs mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_en_o === 1'b1) en_cnt <= en_cnt + 1;
        if (bus.mem_en_o === 1'b1 && bus.mem_we_o === 1'b1)
            wr_log.push_back('{bus.mem_addr_o, bus.mem_wdata_o, cyc});
        if (fix_done_o === 1'b1) done_log.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic push_err(input logic [12:0] a, input bit last, input bit expect_wr);
        bus.err_vld_i  = 1'b1;
        bus.err_addr_i = a;
        bus.err_last_i = last;
        if (expect_wr) exp_q.push_back('{a[12:3], 8'h01 << a[2:0]});
        step();
        bus.err_vld_i  = 1'b0;
        bus.err_last_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_log.size() != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_logs();
        exp_q.delete();
        wr_log.delete();
        done_log.delete();
    endtask

    // Scoreboard: pair observed writes with expected repairs in order.
    task automatic drain(input string name);
        exp_t       e;
        wr_t        o;
        logic [7:0] want;
        while (exp_q.size() > 0 && wr_log.size() > 0) begin
            e    = exp_q.pop_front();
            o    = wr_log.pop_front();
            want = ref_mem[e.byte_idx] ^ e.mask;
            ref_mem[e.byte_idx] = want;
            checks++;
            if (o.addr !== AW'(e.byte_idx) || o.data !== want) begin
                errors++;
                $display("FAIL %s write: got addr %0d data %h, want addr %0d data %h",
                         name, o.addr, o.data, e.byte_idx, want);
            end
        end
        checks++;
        if (exp_q.size() != 0 || wr_log.size() != 0) begin
            errors++;
            $display("FAIL %s write count: %0d expected writes missing, %0d unexpected writes",
                     name, exp_q.size(), wr_log.size());
        end
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; fail_i = 1'b0;
        bus.err_vld_i = 1'b0; bus.err_addr_i = '0; bus.err_last_i = 1'b0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = pat(i);
        step(); step();
        checks++;
        if ({bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_mem: got en %b we %b addr %0d wdata %h, want all 0",
                     bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
        end
        checks++;
        if ({fix_busy_o, fix_done_o, fix_fail_o, fix_ovf_o, fix_cnt_o, skip_cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_status: got busy %b done %b fail %b ovf %b cnt %0d skip %0d, want all 0",
                     fix_busy_o, fix_done_o, fix_fail_o, fix_ovf_o, fix_cnt_o, skip_cnt_o);
        end
        rst = 1'b0;
        step();
        clear_logs();
    endtask

    task automatic test_basic();
        int c0;
        int got;
        bit ok;
        clear_logs();
        pulse_start();
        checks++;
        if (fix_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b want 1", fix_busy_o);
        end
        c0 = cyc;
        push_err(13'h0008, 1'b0, 1'b1);
        push_err(13'h0011, 1'b0, 1'b1);
        push_err(13'h0FFF, 1'b1, 1'b1);
        wait_done(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done: no done pulse within 100 cycles");
        end
        got = (wr_log.size() > 0) ? wr_log[0].cyc : -1;
        checks++;
        if (got != c0 + 4) begin
            errors++;
            $display("FAIL basic_latency: first write at cycle %0d, want %0d", got, c0 + 4);
        end
        step(); step();
        drain("basic");
        checks++;
        if (fix_cnt_o !== 5'd3 || skip_cnt_o !== 4'd0 || done_log.size() != 0 || fix_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: got cnt %0d skip %0d extra done %0d busy %b, want 3 0 0 0",
                     fix_cnt_o, skip_cnt_o, done_log.size(), fix_busy_o);
        end
    endtask

    task automatic test_parity_skip();
        bit ok;
        clear_logs();
        pulse_start();
        push_err(13'h1008, 1'b0, 1'b0);
        push_err(13'h0000, 1'b1, 1'b1);
        wait_done(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL parity_done: no done pulse within 100 cycles");
        end
        drain("parity");
        checks++;
        if (fix_cnt_o !== 5'd1 || skip_cnt_o !== 4'd1) begin
            errors++;
            $display("FAIL parity_counts: got cnt %0d skip %0d, want 1 1", fix_cnt_o, skip_cnt_o);
        end
    endtask

    // Back-to-back pushes outrun the 3-cycle service rate: the queue fills
    // at push 23 (accepted alongside a pop) and pushes 24 and 25 are dropped.
    task automatic test_back_to_back();
        bit ok;
        clear_logs();
        pulse_start();
        for (int i = 0; i < 26; i++) begin
            push_err({10'(100 + i), 3'(i % 8)}, (i == 25), (i < 24));
            if (i == 23) begin
                checks++;
                if (fix_ovf_o !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early: got %b after push 23, want 0", fix_ovf_o);
                end
            end
            if (i == 24) begin
                checks++;
                if (fix_ovf_o !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_set: got %b after push 24, want 1", fix_ovf_o);
                end
            end
        end
        wait_done(300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_done: no done pulse within 300 cycles");
        end
        drain("b2b");
        checks++;
        if (fix_cnt_o !== 5'd24 || fix_ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_status: got cnt %0d ovf %b, want 24 1", fix_cnt_o, fix_ovf_o);
        end
    endtask

    task automatic test_duplicate();
        bit ok;
        clear_logs();
        pulse_start();
        push_err(13'h0025, 1'b0, 1'b1);
        push_err(13'h0025, 1'b1, 1'b1);
        wait_done(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL dup_done: no done pulse within 100 cycles");
        end
        drain("dup");
        checks++;
        if (mem[4] !== pat(4) || fix_cnt_o !== 5'd2) begin
            errors++;
            $display("FAIL dup_final: got byte4 %h cnt %0d, want %h 2", mem[4], fix_cnt_o, pat(4));
        end
    endtask

    task automatic test_fail();
        clear_logs();
        pulse_start();
        push_err(13'h0100, 1'b0, 1'b0);
        push_err(13'h0108, 1'b0, 1'b0);
        checks++;
        if (bus.mem_en_o !== 1'b1 || bus.mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL fail_rd: got en %b we %b in RD, want 1 0", bus.mem_en_o, bus.mem_we_o);
        end
        step();
        fail_i = 1'b1;
        step();
        fail_i = 1'b0;
        checks++;
        if (fix_done_o !== 1'b1 || fix_fail_o !== 1'b1 || fix_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL fail_done: got done %b fail %b busy %b, want 1 1 0",
                     fix_done_o, fix_fail_o, fix_busy_o);
        end
        repeat (8) step();
        checks++;
        if (wr_log.size() != 0 || done_log.size() != 1 || fix_cnt_o !== 5'd0) begin
            errors++;
            $display("FAIL fail_after: got writes %0d dones %0d cnt %0d, want 0 1 0",
                     wr_log.size(), done_log.size(), fix_cnt_o);
        end
        clear_logs();
    endtask

    task automatic test_last_only_and_reset();
        int en0;
        clear_logs();
        en0 = en_cnt;
        pulse_start();
        bus.err_last_i = 1'b1;
        step();
        bus.err_last_i = 1'b0;
        checks++;
        if (fix_done_o !== 1'b0) begin
            errors++;
            $display("FAIL last_early: got done %b one cycle after last, want 0", fix_done_o);
        end
        step();
        checks++;
        if (fix_done_o !== 1'b1) begin
            errors++;
            $display("FAIL last_done: got done %b two cycles after last, want 1", fix_done_o);
        end
        step();
        checks++;
        if (en_cnt != en0 || fix_cnt_o !== 5'd0 || skip_cnt_o !== 4'd0 || fix_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL last_status: got accesses %0d cnt %0d skip %0d busy %b, want 0 0 0 0",
                     en_cnt - en0, fix_cnt_o, skip_cnt_o, fix_busy_o);
        end
        clear_logs();
        pulse_start();
        push_err(13'h0040, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.mem_en_o !== 1'b1 || bus.mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_rd: got en %b we %b, want 1 0 before reset", bus.mem_en_o, bus.mem_we_o);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, fix_busy_o,
             fix_done_o, fix_fail_o, fix_ovf_o, fix_cnt_o, skip_cnt_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid: got en %b we %b busy %b done %b cnt %0d, want all 0",
                     bus.mem_en_o, bus.mem_we_o, fix_busy_o, fix_done_o, fix_cnt_o);
        end
        rst = 1'b0;
        repeat (6) step();
        checks++;
        if (wr_log.size() != 0 || fix_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: got writes %0d busy %b, want 0 0", wr_log.size(), fix_busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_skip();
        test_back_to_back();
        test_duplicate();
        test_fail();
        test_last_only_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
